hazard_forward_unit: RTL and testbench
======================================

# hazard_forward_unit

Parametrised hazard and forwarding unit for the MIPS150 pipeline; next generation of the decode-side forwarding selects in the control path. Keeps its own scoreboard of in-flight register writes over `DEPTH` stages and drives the ALU operand-source selects. Generates load-use stalls and squashes on branch/jump redirect and after reset. Sits beside the decode stage: it takes decoded fields of the instruction in ID, and the datapath consumes `fwd_a`/`fwd_b` when building the execute operands.

## Interface
- `REG_W`, 5: register-specifier width.
- `DEPTH`, 2: producer stages tracked past ID (1..4); stage 1 is the youngest.
- `LOAD_LAT`, 1: extra stages before load data can be forwarded (0..DEPTH-1).
- `FW`, clog2(DEPTH+1): width of the forward selects (derived; not overridden).
- `CNT_W`, 16: stall-counter width.

Ports:
- `clk` in 1: clock; all state on rising edge.
- `rst` in 1: synchronous, active-low reset.
- `advance` in 1: pipeline enable; 0 freezes all state.
- `redirect` in 1: taken branch or jump resolved this cycle.
- `id_valid` in 1: ID holds a real instruction.
- `id_rs`, `id_rt` in REG_W: source specifiers.
- `id_uses_rs`, `id_uses_rt` in 1: the source is actually read.
- `id_wr` in 1: instruction writes a register.
- `id_dst` in REG_W: destination (rd for R-type, rt for I-type/load, 31 for JAL).
- `id_is_load` in 1: instruction is LB/LH/LW/LBU/LHU.
- `stall` out 1: hold IF/ID and insert a bubble.
- `flush` out 1: squash IF/ID.
- `fwd_a`, `fwd_b` out FW: 0 = register file, k = result of stage k.
- `stall_count` out CNT_W: saturating count of stall cycles.

## Operation
- **Scoreboard entry (stages 1..DEPTH):** `{v, dst, wait}`, where `wait` is 0..LOAD_LAT.
- **Insert into stage 1 on `advance`:** `v = id_valid & id_wr & (id_dst != 0) & ~stall & ~flush`, `dst = id_dst`, `wait = id_is_load ? LOAD_LAT : 0`. Otherwise stage 1 gets a bubble (v=0).
- **Shift on `advance`:** stage k+1 <= stage k, with `wait` decremented (saturating at 0). Stage DEPTH retires; the register file's write-through handles anything older.
- **Source match:** a source matches stage k if `id_uses_x & id_valid & (x != 0) & v[k] & (dst[k] == x)`.
- **Youngest match wins:** the smallest matching k is chosen.
  - If `wait[k] == 0`: `fwd_x = k`.
  - If `wait[k] != 0`: hazard for that source.
  - No match: `fwd_x = 0`.
- **Stall:** `stall = (hazard_a | hazard_b) & ~flush`.
- **Flush:** `flush = redirect | (rcnt != 0)`.
- **Precedence:** redirect beats stall. With redirect and hazard together, stall=0, flush=1, and stage 1 gets a bubble.
- **Forward selects:** forced to 0 while `flush` or `stall` is 1.
- **Reset flush counter `rcnt`:** loaded with DEPTH+1 on reset, decrements each cycle with rst high, independent of `advance`.
- **stall_count:** +1 on each cycle with `stall & advance`; holds at all-ones.
- **Freeze (`advance` = 0):** scoreboard and `stall_count` hold. Outputs are still computed combinationally from held state and current ID inputs.
- **Reset mid-operation:** all `v` cleared, `stall_count` = 0, `rcnt` = DEPTH+1, regardless of `advance`.

## Timing
- **Outputs:** combinational from registered scoreboard plus same-cycle ID inputs. No added latency.
- **Values while `rst` is low:** `stall` = 0, `flush` = 1, `fwd_a` = `fwd_b` = 0, `stall_count` = 0.
- **After reset release:** `flush` is high for exactly DEPTH+1 cycles (3 at default), then follows `redirect`.
- **Load-use stall length:** LOAD_LAT+1−k cycles for a consumer that first sees the load in stage k, given continuous `advance`. Default LOAD_LAT=1: consumer directly behind a load stalls 1 cycle, then gets `fwd` = 2.
- **Bubbles on stall:** the stalled instruction is never entered in the scoreboard. It re-evaluates next cycle with identical ID inputs.
- **Back-to-back forwarding:** an ALU producer is visible to the very next ID instruction as `fwd` = 1.

## Test plan
All scenarios use defaults (DEPTH=2, LOAD_LAT=1) and run after the 3-cycle reset flush.
- **Back-to-back ALU:** ADDU $3, then ID rs=3 gives `fwd_a`=1, stall=0. Next cycle, ID rt=3 gives `fwd_b`=2. Third instruction with rs=3 gives `fwd_a`=0.
- **Load-use:** LW $5, then ID rs=5 gives stall=1 for 1 cycle with `fwd_a`=0 and `stall_count` 0→1. Next cycle stall=0, `fwd_a`=2. A stage-2 load (one intervening instruction) gives no stall and `fwd` = 2.
- **$0 and priority:** writing $0 then reading rs=0 gives `fwd_a`=0. Stage 1 and stage 2 both with dst=7 and rs=7 gives `fwd_a`=1. `id_uses_rt`=0 with a matching rt gives `fwd_b`=0 and no stall.
- **Redirect vs stall:** LW $5 followed by ID rs=5 with `redirect`=1 gives flush=1, stall=0, `stall_count` unchanged. Next cycle stage 1 is invalid.
- **Freeze:** `advance`=0 for 4 cycles during a load-use hazard gives stall=1 throughout, `stall_count` unchanged, scoreboard held. Resuming `advance` gives exactly 1 counted stall.
- **Reset:** pull `rst` low for 1 cycle mid-hazard. Required: flush=1 for that cycle plus 3 after release, `stall_count`=0, and all forwards 0 until new producers issue. Saturation check: preload a run of 65535 stalls, then one more keeps `stall_count`=0xFFFF.

Source files
------------

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding unit for the MIPS150 pipeline: tracks in-flight register
// writes over DEPTH stages, drives ALU operand forward selects, load-use stalls and flushes.
module hazard_forward_unit #(
  parameter  int REG_W    = 5,
  parameter  int DEPTH    = 2,
  parameter  int LOAD_LAT = 1,
  parameter  int CNT_W    = 16,
  localparam int FW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  input  logic             redirect,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_wr,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_is_load,
  output logic             stall,
  output logic             flush,
  output logic [FW-1:0]    fwd_a,
  output logic [FW-1:0]    fwd_b,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = (LOAD_LAT > 0) ? $clog2(LOAD_LAT + 1) : 1;
  localparam int RC_W   = $clog2(DEPTH + 2);

  // Stage k of the scoreboard lives at index k-1.
  logic [DEPTH-1:0]             v_q, v_d;
  logic [DEPTH-1:0][REG_W-1:0]  dst_q, dst_d;
  logic [DEPTH-1:0][WAIT_W-1:0] wait_q, wait_d;
  logic [RC_W-1:0]              rcnt_q, rcnt_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic [FW-1:0] sel_a, sel_b;
  logic          haz_a, haz_b;

  // Scan oldest to youngest so the youngest matching stage overrides.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_valid && id_uses_rs && (id_rs != '0) && v_q[k-1] && (dst_q[k-1] == id_rs)) begin
        sel_a = FW'(k);
        haz_a = (wait_q[k-1] != '0);
      end
      if (id_valid && id_uses_rt && (id_rt != '0) && v_q[k-1] && (dst_q[k-1] == id_rt)) begin
        sel_b = FW'(k);
        haz_b = (wait_q[k-1] != '0);
      end
    end
  end

  always_comb begin
    flush       = ~rst | redirect | (rcnt_q != '0);
    stall       = (haz_a | haz_b) & ~flush;
    fwd_a       = (flush | stall) ? '0 : sel_a;
    fwd_b       = (flush | stall) ? '0 : sel_b;
    stall_count = rst ? cnt_q : '0;
  end

  always_comb begin
    v_d    = v_q;
    dst_d  = dst_q;
    wait_d = wait_q;
    cnt_d  = cnt_q;
    rcnt_d = (rcnt_q != '0) ? rcnt_q - 1'b1 : rcnt_q;
    if (advance) begin
      v_d[0]    = id_valid & id_wr & (id_dst != '0) & ~stall & ~flush;
      dst_d[0]  = id_dst;
      wait_d[0] = id_is_load ? WAIT_W'(LOAD_LAT) : '0;
      for (int k = 1; k < DEPTH; k++) begin
        v_d[k]    = v_q[k-1];
        dst_d[k]  = dst_q[k-1];
        wait_d[k] = (wait_q[k-1] != '0) ? wait_q[k-1] - 1'b1 : '0;
      end
      if (stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      v_q    <= '0;
      dst_q  <= '0;
      wait_q <= '0;
      rcnt_q <= RC_W'(DEPTH + 1);
      cnt_q  <= '0;
    end else begin
      v_q    <= v_d;
      dst_q  <= dst_d;
      wait_q <= wait_d;
      rcnt_q <= rcnt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed self-checking bench for hazard_forward_unit at default parameters,
// plus a narrow-counter instance that exercises stall_count saturation.
module tb_hazard_forward_unit;

  logic        clk;
  logic        rst;
  logic        advance;
  logic        redirect;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        id_wr;
  logic [4:0]  id_dst;
  logic        id_is_load;
  logic        stall;
  logic        flush;
  logic [1:0]  fwd_a;
  logic [1:0]  fwd_b;
  logic [15:0] stall_count;

  logic        sat_stall;
  logic        sat_flush;
  logic [1:0]  sat_fwd_a;
  logic [1:0]  sat_fwd_b;
  logic [3:0]  sat_count;

  int checks   = 0;
  int failures = 0;

  hazard_forward_unit #(.REG_W(5), .DEPTH(2), .LOAD_LAT(1), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .advance(advance), .redirect(redirect),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr(id_wr), .id_dst(id_dst), .id_is_load(id_is_load),
    .stall(stall), .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_count(stall_count)
  );

  // Same stimulus, 4-bit counter so saturation is reachable in a few cycles.
  hazard_forward_unit #(.REG_W(5), .DEPTH(2), .LOAD_LAT(1), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .advance(advance), .redirect(redirect),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_wr(id_wr), .id_dst(id_dst), .id_is_load(id_is_load),
    .stall(sat_stall), .flush(sat_flush), .fwd_a(sat_fwd_a), .fwd_b(sat_fwd_b),
    .stall_count(sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] rs, input logic urs,
                               input logic [4:0] rt, input logic urt, input logic wr,
                               input logic [4:0] dst, input logic load);
    id_valid   = valid;
    id_rs      = rs;
    id_uses_rs = urs;
    id_rt      = rt;
    id_uses_rt = urt;
    id_wr      = wr;
    id_dst     = dst;
    id_is_load = load;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    rst      = 1'b0;
    advance  = 1'b1;
    redirect = 1'b0;
    idle();

    tick();
    tick();
    checkOutput("rst_flush", flush, 1);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_fwd_a", fwd_a, 0);
    checkOutput("rst_fwd_b", fwd_b, 0);
    checkOutput("rst_count", stall_count, 0);

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle();
      checkOutput($sformatf("post_rst_flush%0d", i), flush, 1);
      tick();
    end
    idle();
    checkOutput("post_rst_flush_done", flush, 0);
    tick();

    $display("[TB] back-to-back ALU");
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b0);
    checkOutput("alu_prod_stall", stall, 0);
    tick();
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0);
    checkOutput("alu_fwd_a1", fwd_a, 1);
    checkOutput("alu_stall", stall, 0);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("alu_fwd_b2", fwd_b, 2);
    tick();
    applyStimulus(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("alu_fwd_a0", fwd_a, 0);
    tick();

    $display("[TB] load-use");
    applyStimulus(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
    checkOutput("lu_stall", stall, 1);
    checkOutput("lu_fwd_a_stall", fwd_a, 0);
    checkOutput("lu_count0", stall_count, 0);
    tick();
    checkOutput("lu_release", stall, 0);
    checkOutput("lu_fwd_a2", fwd_a, 2);
    checkOutput("lu_count1", stall_count, 1);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("ld_s2_stall", stall, 0);
    checkOutput("ld_s2_fwd_a", fwd_a, 2);
    tick();

    $display("[TB] zero register and priority");
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("r0_fwd_a", fwd_a, 0);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    tick();
    applyStimulus(1'b1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("prio_fwd_a", fwd_a, 1);
    checkOutput("unused_rt_fwd_b", fwd_b, 0);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd11, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("unused_rt_stall", stall, 0);
    checkOutput("unused_rt_ld_fwd_b", fwd_b, 0);
    tick();
    idle();
    tick();

    $display("[TB] redirect vs stall");
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    tick();
    redirect = 1'b1;
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd12, 1'b0);
    checkOutput("redir_flush", flush, 1);
    checkOutput("redir_stall", stall, 0);
    checkOutput("redir_fwd_a", fwd_a, 0);
    tick();
    redirect = 1'b0;
    applyStimulus(1'b1, 5'd12, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0);
    checkOutput("redir_s1_bubble", fwd_a, 0);
    checkOutput("redir_load_s2", fwd_b, 2);
    checkOutput("redir_count", stall_count, 1);
    tick();
    idle();
    tick();

    $display("[TB] freeze");
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    tick();
    advance = 1'b0;
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("frz_stall%0d", i), stall, 1);
      checkOutput($sformatf("frz_count%0d", i), stall_count, 1);
      tick();
    end
    advance = 1'b1;
    #1;
    checkOutput("frz_resume_stall", stall, 1);
    tick();
    checkOutput("frz_after_stall", stall, 0);
    checkOutput("frz_after_fwd_a", fwd_a, 2);
    checkOutput("frz_after_count", stall_count, 2);
    tick();
    idle();
    tick();

    $display("[TB] reset mid-hazard");
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    tick();
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    checkOutput("mid_pre_stall", stall, 1);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_flush", flush, 1);
    checkOutput("mid_rst_stall", stall, 0);
    checkOutput("mid_rst_count", stall_count, 0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("mid_flush%0d", i), flush, 1);
      checkOutput($sformatf("mid_fwd%0d", i), fwd_a, 0);
      tick();
    end
    #1;
    checkOutput("mid_flush_done", flush, 0);
    checkOutput("mid_no_stall", stall, 0);
    checkOutput("mid_fwd_a_clear", fwd_a, 0);
    checkOutput("mid_count_clear", stall_count, 0);
    tick();
    idle();
    tick();

    $display("[TB] counter saturation");
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1);
    for (int i = 0; i < 30; i++) tick();
    checkOutput("sat_reach_narrow", sat_count, 15);
    checkOutput("sat_reach_wide", stall_count, 15);
    tick();
    tick();
    checkOutput("sat_hold_narrow", sat_count, 15);
    checkOutput("sat_wide_counts", stall_count, 16);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
